// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one multi-cycle ALU among NREQ requesters.
// Grant to response in 3 cycles plus ALU busy time; no grant while the ALU is busy, requests are held until rsp_valid.
module alu_sched #(
    parameter int NREQ = 4,
    parameter int W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   req_op,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [W-1:0]        rsp_data,
    output logic                rsp_err,
    output logic [7:0]          rsp_cycles,
    output logic                alu_start,
    output logic [3:0]          alu_opcode,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    input  logic [W-1:0]        alu_result,
    input  logic                alu_busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IW-1:0]  r_last;
    logic [IW-1:0]  r_idx;
    logic [IW-1:0]  w_win;
    logic [IW-1:0]  w_cand;
    logic           w_found;
    logic           w_grant;
    logic           w_legal;

    logic [3:0]     w_op [NREQ];
    logic [W-1:0]   w_a  [NREQ];
    logic [W-1:0]   w_b  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_op[g] = req_op[4*g +: 4];
        assign w_a[g]  = req_a[W*g +: W];
        assign w_b[g]  = req_b[W*g +: W];
    end

    // Search starts one past the last winner and wraps.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(r_last) + k) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_legal = (w_op[w_win] <= 4'h9);
    assign w_grant = (r_state == S_IDLE) && w_found && !alu_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        alu_start = 1'b0;
        rsp_valid = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = w_legal ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                alu_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (!alu_busy) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = NREQ'(1) << r_idx;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Illegal opcodes never touch the ALU command registers, so those hold their last issued values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= IW'(NREQ - 1);
            r_idx      <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            rsp_cycles <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            if (w_grant) begin
                r_last     <= w_win;
                r_idx      <= w_win;
                rsp_err    <= !w_legal;
                rsp_cycles <= '0;
                if (w_legal) begin
                    alu_opcode <= w_op[w_win];
                    alu_a      <= w_a[w_win];
                    alu_b      <= w_b[w_win];
                end else begin
                    rsp_data   <= '0;
                end
            end
            if (r_state == S_WAIT) begin
                if (rsp_cycles != 8'hFF) begin
                    rsp_cycles <= rsp_cycles + 8'd1;
                end
                if (!alu_busy) begin
                    rsp_data <= alu_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Randomized bench for alu_sched: a transaction-level timeline model predicts grants,
// response cycles and data, while a bench-side ALU supplies variable-latency results.
module tb_alu_sched;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int OPW  = 4 * NREQ;
    localparam int DW   = W * NREQ;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [OPW-1:0]   req_op;
    logic [DW-1:0]    req_a;
    logic [DW-1:0]    req_b;
    logic [NREQ-1:0]  rsp_valid;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;
    logic [7:0]       rsp_cycles;
    logic             alu_start;
    logic [3:0]       alu_opcode;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [W-1:0]     alu_result;
    logic             alu_busy;

    always #5 clk = ~clk;

    alu_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .rsp_cycles (rsp_cycles),
        .alu_start  (alu_start),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_busy   (alu_busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Requester side
    bit           rq_on [NREQ];
    logic [3:0]   rq_op [NREQ];
    logic [W-1:0] rq_a  [NREQ];
    logic [W-1:0] rq_b  [NREQ];
    bit           auto_rereq = 0;
    bit           rand_mode = 0;
    int           rst_at = -1;

    // Bench ALU
    int alu_cnt = 0;
    bit alu_prev_start = 0;
    int extra_lat = 0;

    // Reference timeline
    bit           m_pend = 0;
    int           m_idx, m_gcyc, m_rcyc, m_L;
    bit           m_legal;
    logic [3:0]   m_op;
    logic [W-1:0] m_a, m_b;
    int           m_last = NREQ - 1;
    int           m_free = 0;
    int           order_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << b[3:0];
            4'h6: return a >> b[3:0];
            4'h7: return ~a;
            4'h8: return a * b;
            4'h9: return (b == '0) ? '0 : a / b;
            default: return '0;
        endcase
    endfunction

    // Number of WAIT cycles an op occupies, including the completion cycle.
    function automatic int lat_of(input logic [3:0] op);
        return ((op == 4'h8) ? 6 : (op == 4'h9) ? 10 : 1) + extra_lat;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic bit any_on();
        bit r = 0;
        for (int i = 0; i < NREQ; i++) r |= rq_on[i];
        return r;
    endfunction

    task automatic new_req(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        rq_on[i] = 1;
        rq_op[i] = op;
        rq_a[i]  = a;
        rq_b[i]  = b;
    endtask

    task automatic step();
        logic [NREQ-1:0] v;
        logic [OPW-1:0]  vo;
        logic [DW-1:0]   va, vb;
        bit done, exp_start, found;
        int just_done, dut_idx, j;
        @(negedge clk);
        cyc++;
        done = 0;
        if (alu_prev_start) begin
            alu_cnt = lat_of(alu_opcode) - 1;
            done = (alu_cnt == 0);
        end else if (alu_cnt > 0) begin
            alu_cnt--;
            done = (alu_cnt == 0);
        end
        alu_busy = (alu_cnt != 0);
        alu_result = done ? alu_f(alu_opcode, alu_a, alu_b) : W'($urandom);
        alu_prev_start = alu_start;

        if (rst) begin
            check("rst_data", 32'(rsp_data), 0);
            check("rst_err", 32'(rsp_err), 0);
            check("rst_cycles", 32'(rsp_cycles), 0);
            check("rst_opcode", 32'(alu_opcode), 0);
            check("rst_alu_a", 32'(alu_a), 0);
            check("rst_alu_b", 32'(alu_b), 0);
            rst = 0;
        end

        exp_start = m_pend && m_legal && (cyc == m_gcyc + 1);
        check("alu_start", 32'(alu_start), 32'(exp_start));
        check("start_while_busy", 32'(alu_start & alu_busy), 0);
        if (m_pend && m_legal && cyc > m_gcyc && cyc < m_rcyc) begin
            check("alu_opcode_hold", 32'(alu_opcode), 32'(m_op));
            check("alu_a_hold", 32'(alu_a), 32'(m_a));
            check("alu_b_hold", 32'(alu_b), 32'(m_b));
        end

        if (rsp_valid != '0) begin
            dut_idx = -1;
            for (int i = 0; i < NREQ; i++) if (rsp_valid == onehot(i)) dut_idx = i;
            order_q.push_back(dut_idx);
        end

        just_done = -1;
        if (m_pend && cyc == m_rcyc) begin
            check("rsp_valid", 32'(rsp_valid), 32'(onehot(m_idx)));
            check("rsp_data", 32'(rsp_data), m_legal ? 32'(alu_f(m_op, m_a, m_b)) : 0);
            check("rsp_err", 32'(rsp_err), 32'(!m_legal));
            check("rsp_cycles", 32'(rsp_cycles), m_legal ? ((m_L > 255) ? 255 : m_L) : 0);
            rq_on[m_idx] = 0;
            just_done = m_idx;
            m_pend = 0;
            m_free = cyc + 1;
        end else begin
            check("rsp_valid_quiet", 32'(rsp_valid), 0);
        end

        if (cyc == rst_at) begin
            rst = 1;
            m_pend = 0;
            m_last = NREQ - 1;
            m_free = cyc + 1;
        end

        for (int i = 0; i < NREQ; i++) begin
            if (!rq_on[i] && i != just_done) begin
                if (auto_rereq) new_req(i, 4'h2, W'($urandom), W'($urandom));
                else if (rand_mode && $urandom_range(0, 3) == 0)
                    new_req(i, 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
            end
        end

        if (!rst && !m_pend && cyc >= m_free && !alu_busy) begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                j = (m_last + k) % NREQ;
                if (!found && rq_on[j]) begin
                    found   = 1;
                    m_idx   = j;
                    m_op    = rq_op[j];
                    m_a     = rq_a[j];
                    m_b     = rq_b[j];
                    m_legal = (rq_op[j] <= 4'h9);
                    m_L     = lat_of(rq_op[j]);
                    m_gcyc  = cyc;
                    m_rcyc  = m_legal ? cyc + 2 + m_L : cyc + 1;
                    m_last  = j;
                    m_pend  = 1;
                end
            end
        end

        v = '0; vo = '0; va = '0; vb = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rq_on[i]) v |= NREQ'(1) << i;
            vo |= OPW'(rq_op[i]) << (4 * i);
            va |= DW'(rq_a[i]) << (W * i);
            vb |= DW'(rq_b[i]) << (W * i);
        end
        req = v; req_op = vo; req_a = va; req_b = vb;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((m_pend || any_on()) && n < budget);
        if (m_pend || any_on()) check("idle_timeout", 1, 0);
    endtask

    initial begin
        int exp_order[5];
        int n;
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1;
        req = '0; req_op = '0; req_a = '0; req_b = '0;
        alu_busy = 0; alu_result = '0;
        for (int i = 0; i < NREQ; i++) begin
            rq_on[i] = 0; rq_op[i] = '0; rq_a[i] = '0; rq_b[i] = '0;
        end

        // All four requesting op 0x2 continuously from reset.
        auto_rereq = 1;
        n = 0;
        while (order_q.size() < 5 && n < 200) begin
            step();
            n++;
        end
        auto_rereq = 0;
        for (int i = 0; i < 5; i++) begin
            check("rr_order", (i < order_q.size()) ? order_q[i] : -1, exp_order[i]);
            if (i > 0 && i < order_q.size()) check("rr_no_repeat", 32'(order_q[i] == order_q[i-1]), 0);
        end
        run_until_idle(200);

        new_req(0, 4'h0, 16'h1234, 16'h0001); run_until_idle(50);
        new_req(2, 4'h8, 16'd7, 16'd6);       run_until_idle(50);
        new_req(1, 4'h9, 16'd100, 16'd0);     run_until_idle(50);
        new_req(3, 4'hC, 16'hBEEF, 16'h1111); run_until_idle(50);

        // Reset three cycles into a long op while the ALU is still busy.
        new_req(1, 4'h9, 16'd100, 16'd7);
        n = 0;
        while (!m_pend && n < 50) begin
            step();
            n++;
        end
        if (!m_pend) check("grant_timeout", 1, 0);
        rst_at = m_gcyc + 3;
        run_until_idle(100);

        // Very long ALU op to saturate the cycle counter.
        extra_lat = 300;
        new_req(0, 4'h0, 16'h0010, 16'h0020);
        run_until_idle(400);
        extra_lat = 0;

        rand_mode = 1;
        repeat (2500) step();
        rand_mode = 0;
        run_until_idle(300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (fixed at 4 for this revision).
REQ-002 Parameter: W, 16, operand/result width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  NREQ  per-requester level request; held high until that requester's rsp_valid bit is seen.
REQ-006 req_op  in  4*NREQ  packed opcodes, requester i at [4i+3:4i].
REQ-007 req_a, req_b  in  W*NREQ each  packed operands, requester i at [Wi+W-1:Wi].
REQ-008 rsp_valid  out  NREQ  one-hot, one-cycle completion pulse to the served requester.
REQ-009 rsp_data  out  W  result; valid only while rsp_valid is nonzero.
REQ-010 rsp_err  out  1  illegal-opcode flag; valid with rsp_valid.
REQ-011 rsp_cycles  out  8  WAIT-state cycles spent on this operation, saturating at 255.
REQ-012 alu_start  out  1  start strobe to the ALU.
REQ-013 alu_opcode  out  4; alu_a, alu_b  out  W  ALU command and operands.
REQ-014 alu_result  in  W; alu_busy  in  1  ALU outputs.

Function
REQ-015 The block SHALL use four states: IDLE, ISSUE, WAIT, RESP.
REQ-016 Arbitration in IDLE SHALL be round-robin: search starts at last-granted index + 1 and wraps modulo NREQ.
REQ-017 IDLE SHALL grant only when some req bit is 1 and alu_busy = 0; otherwise it stays in IDLE.
REQ-018 On grant, the block SHALL latch the winner's index, opcode, A and B, and update last-granted to the winner.
REQ-019 Opcodes 0x0-0x9 SHALL be legal.
  - Legal opcode: IDLE -> ISSUE.
  - 0xA-0xF: IDLE -> RESP with rsp_err = 1 and rsp_data = 0; no alu_start is issued.
REQ-020 alu_start SHALL be 1 exactly in the ISSUE cycle; ISSUE -> WAIT unconditionally.
REQ-021 alu_opcode, alu_a and alu_b SHALL equal the latched values from ISSUE through the last WAIT cycle, because the ALU samples operands at completion of multi-cycle ops.
REQ-022 When not in ISSUE or WAIT, alu_opcode, alu_a and alu_b SHALL hold their last values.
REQ-023 WAIT SHALL exit to RESP in the first WAIT cycle with alu_busy = 0, capturing alu_result into rsp_data.
REQ-024 rsp_cycles SHALL count WAIT cycles including the exit cycle: single-cycle op = 1, opcode 0x8 = 6, opcode 0x9 = 10.
REQ-025 In RESP, rsp_valid[idx] SHALL be 1 for exactly one cycle, and rsp_data, rsp_err and rsp_cycles SHALL be stable in that cycle; RESP -> IDLE.
REQ-026 End-to-end latency from the IDLE grant cycle to the RESP cycle SHALL be 3 cycles (ops 0x0-0x7), 8 (0x8) and 12 (0x9); an illegal opcode SHALL reach RESP 1 cycle after grant.
REQ-027 A requester SHALL be granted at most once per RESP; a requester deasserts req at the clock edge on which it samples its rsp_valid.
REQ-028 A req deasserted after grant SHALL NOT abort the operation; the RESP pulse is still issued.
REQ-029 req changes by non-granted requesters during ISSUE, WAIT or RESP SHALL have no effect until the next IDLE cycle.
REQ-030 rsp_valid SHALL be 0 in all states other than RESP.

Reset
REQ-031 With rst = 1 at a clock edge, the block SHALL enter IDLE with last-granted = NREQ-1, so requester 0 has first priority.
REQ-032 Reset values: rsp_valid = 0, rsp_data = 0, rsp_err = 0, rsp_cycles = 0, alu_start = 0, alu_opcode = 0, alu_a = 0, alu_b = 0.
REQ-033 Reset asserted mid-operation SHALL abort it with no rsp_valid pulse.
REQ-034 After reset, no new grant SHALL occur until alu_busy = 0 (covered by REQ-017).

Verification
REQ-035 Scenario: req[0], op 0x0, A=0x1234, B=0x0001 -> one alu_start pulse; rsp_valid = 0001 3 cycles after grant; rsp_data = 0x1235; rsp_cycles = 1.
REQ-036 Scenario: req[2], op 0x8, A=7, B=6 -> rsp_valid = 0100 8 cycles after grant; rsp_data = 42; alu_a = 7 throughout WAIT; rsp_cycles = 6.
REQ-037 Scenario: req[1], op 0x9, A=100, B=0 -> rsp_data = 0 after 12 cycles; rsp_cycles = 10.
REQ-038 Scenario: req = 1111 held, all op 0x2 -> grant order 0,1,2,3,0; each rsp_valid one-hot; no back-to-back repeat of the same requester.
REQ-039 Scenario: req[3], op 0xC -> rsp_valid = 1000 1 cycle after grant; rsp_err = 1; rsp_data = 0; alu_start never asserted.
REQ-040 Scenario: rst pulsed 3 cycles into a 0x9 op while the ALU stays busy -> no rsp_valid pulse; no alu_start while alu_busy = 1; the next request completes normally.
